quad_steer_decoder: RTL and testbench
=====================================

// Module: quad_steer_decoder
//
// PURPOSE
//   Receive side of the joystick-to-quadrature steering path. Takes a 2-bit
//   quadrature pair (A/B, asynchronous, possibly bouncy) and produces
//   per-step strobes, direction, a wrapping position count, an illegal-
//   transition flag and a windowed signed velocity sample.
//   Used to read real spinners and wheels, and as a loopback checker for
//   the quadrature encoder output.
//
// PARAMETERS
//   FILTER_LEN  4      consecutive stable clocks required to accept a new A/B value (>=1; 1 = no filtering)
//   POS_W       8      width of position counter (wraps modulo 2^POS_W)
//   VEL_W       8      width of signed velocity sample
//   WINDOW      22500  velocity sampling window, in CLK cycles (>=2)
//
// PORTS
//   CLK          in   1      single clock; all logic is on its rising edge
//   Reset_n      in   1      asynchronous, active-low reset
//   clr_I        in   1      synchronous clear of position counter
//   A_I          in   1      quadrature phase A, asynchronous
//   B_I          in   1      quadrature phase B, asynchronous
//   step_O       out  1      one-clock pulse per accepted legal step
//   dir_O        out  1      direction of last legal step (1 = forward)
//   pos_O        out  POS_W  position count, unsigned, wrapping
//   vel_O        out  VEL_W  signed steps in last completed window, saturated
//   vel_valid_O  out  1      one-clock pulse when vel_O updates
//   err_O        out  1      one-clock pulse on an illegal (double-bit) transition
//
// BEHAVIOUR
//   Reset: every output = 0. Sync FFs, filter state and counters = 0; init flag set.
//   Sync:  A_I/B_I pass through 2-FF synchronizers as a 2-bit vector s.
//   Filter
//   - Filtered state f updates on the FILTER_LEN-th consecutive clock where
//     s != f and s is unchanged from the previous clock.
//   - Any change of s restarts the count.
//   - Input edge to f update = 2 + FILTER_LEN clocks.
//   Init:  while the init flag is set, the first f update is adopted silently.
//   - No step, no err, no position change.
//   - The flag then clears.
//   Decode: on the edge where f takes a new value, with {A,B}:
//   - Forward sequence 00->01->11->10->00: step_O=1, dir_O<=1, pos+1.
//   - Reverse sequence: step_O=1, dir_O<=0, pos-1.
//   - Both bits changed: err_O=1, no step, pos and dir_O unchanged; f still adopts the new value.
//   - step_O and err_O are high exactly one clock and are mutually exclusive.
//   Position
//   - Wraps: 2^POS_W-1 +1 -> 0; 0 -1 -> 2^POS_W-1.
//   - clr_I forces pos to 0 and overrides a same-cycle step; step_O and dir_O are still reported.
//   Velocity
//   - Window counter runs 0..WINDOW-1.
//   - Accumulator adds +/-1 per step and saturates at +/-(2^(VEL_W-1)-1).
//   - On the clock where the counter = WINDOW-1:
//     - vel_O <= accumulator including that cycle's step, saturated.
//     - vel_valid_O=1.
//     - Accumulator <= 0 and the counter wraps to 0.
//   - clr_I does not affect the velocity path.
//   Reset mid-operation: all state returns to reset values immediately; the
//   first f value after release is adopted via the init rule.
//
// STRUCTURE
//   Package quad_pkg:
//   - Gray state constants QS_00/QS_01/QS_11/QS_10.
//   - DIR_FWD/DIR_REV.
//   - Function quad_step(prev,next) returning {legal,move,dir}.
//   Sub-module quad_input_filter:
//   - 2-FF synchronizer plus joint 2-bit stability filter (parameter FILTER_LEN).
//   - Outputs f and a one-clock update strobe.
//   - Filtering both bits jointly preserves double-bit error detection.
//   Top level holds the decode, position, velocity and init logic.
//
// TESTING
//   1. Reset, init and forward steps (FILTER_LEN=4).
//      - Hold {A,B}=11 through reset, then release: no step/err, pos=0.
//      - Drive 11->10->00->01 at 10-clock spacing: 3 step pulses, each 6 clocks after its edge; dir_O=1, pos=3.
//   2. Reverse and wrap.
//      - From pos=0, drive one reverse step: pos=255 (POS_W=8), dir_O=0.
//      - Drive one forward step: pos=0.
//   3. Glitch rejection.
//      - 3-clock pulses on A: no step_O, pos unchanged.
//      - 4-clock-stable change: exactly one step_O.
//   4. Illegal transition.
//      - Drive 00->11 in one clock: err_O pulses once, step_O=0, pos and dir_O unchanged.
//      - Next legal step 11->10 counts normally.
//   5. Velocity (WINDOW=100, VEL_W=8).
//      - 10 forward steps in one window: vel_O=10 with vel_valid_O on clock 99.
//      - 200 steps in one window (FILTER_LEN=1): vel_O=127.
//      - Step on clock 99 is counted in that window.
//   6. Clear and async reset.
//      - clr_I coincident with a step: pos=0, step_O=1.
//      - Assert Reset_n low mid-window: outputs 0 on the next sampling without a clock edge.

Source files
------------

// File: rtl/quad_pkg.sv
// -----------------------------------------------------------------------------
// quad_pkg
//   Shared definitions for the quadrature receive path.
//   - Gray-coded {A,B} state constants (QS_00 / QS_01 / QS_11 / QS_10).
//   - Direction encodings DIR_FWD / DIR_REV.
//   - quad_step(): classifies one filtered state change as legal/illegal,
//     moved/not-moved, and forward/reverse.
// -----------------------------------------------------------------------------
package quad_pkg;

    // Forward rotation visits the states in this order: 00 -> 01 -> 11 -> 10 -> 00.
    typedef enum logic [1:0] {
        QS_00 = 2'b00,
        QS_01 = 2'b01,
        QS_11 = 2'b11,
        QS_10 = 2'b10
    } quad_state_e;

    localparam logic DIR_FWD = 1'b1;
    localparam logic DIR_REV = 1'b0;

    typedef struct packed {
        logic legal;  // at most one bit changed
        logic move;   // at least one bit changed
        logic dir;    // DIR_FWD / DIR_REV, meaningful only for a legal move
    } quad_step_t;

    function automatic quad_step_t quad_step(input logic [1:0] prev, input logic [1:0] next);
        quad_step_t r;
        logic [1:0] fwd_next;
        case (prev)
            QS_00:   fwd_next = QS_01;
            QS_01:   fwd_next = QS_11;
            QS_11:   fwd_next = QS_10;
            default: fwd_next = QS_00;
        endcase
        r.move  = (prev != next);
        r.legal = ((prev ^ next) != 2'b11);
        r.dir   = (next == fwd_next) ? DIR_FWD : DIR_REV;
        return r;
    endfunction

endpackage : quad_pkg

// File: rtl/quad_input_filter.sv
// -----------------------------------------------------------------------------
// quad_input_filter
//   Brings the asynchronous A/B pair into the clock domain and debounces it.
//   Both bits are filtered as one 2-bit vector so that a genuine simultaneous
//   change of A and B survives as a double-bit transition downstream.
//
//   Timing: an input change reaches f on the (2 + FILTER_LEN)-th rising edge
//   (2 synchronizer stages, then FILTER_LEN consecutive stable samples).
//
// Ports
//   clk     in   1  clock
//   rst_n   in   1  asynchronous active-low reset
//   a_i     in   1  phase A, asynchronous
//   b_i     in   1  phase B, asynchronous
//   s_o     out  2  synchronized {A,B}; the value f adopts when upd_o is high
//   f_o     out  2  filtered {A,B} (registered)
//   upd_o   out  1  high in the cycle whose closing edge loads s_o into f_o
// -----------------------------------------------------------------------------
module quad_input_filter
    import quad_pkg::*;
#(
    parameter int FILTER_LEN = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_i,
    input  logic       b_i,
    output logic [1:0] s_o,
    output logic [1:0] f_o,
    output logic       upd_o
);

    localparam int               CNT_W    = $clog2(FILTER_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN);

    logic [1:0]       meta_q, meta_d;
    logic [1:0]       s_q, s_d;
    logic [1:0]       last_q, last_d;  // s from the previous clock, to detect changes
    logic [1:0]       f_q, f_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] run_len;
    logic             upd;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latch).
        meta_d = {a_i, b_i};
        s_d    = meta_q;
        last_d = s_q;
        f_d    = f_q;
        cnt_d  = '0;
        upd    = 1'b0;

        // Length of the current run of identical s samples, including this one.
        // A change of s restarts the run at 1.
        run_len = (s_q == last_q) ? cnt_q + 1'b1 : CNT_W'(1);

        if (s_q != f_q) begin
            if (run_len >= CNT_LAST) begin
                f_d = s_q;
                upd = 1'b1;
            end else begin
                cnt_d = run_len;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 2'b00;
            s_q    <= 2'b00;
            last_q <= 2'b00;
            f_q    <= QS_00;
            cnt_q  <= '0;
        end else begin
            meta_q <= meta_d;
            s_q    <= s_d;
            last_q <= last_d;
            f_q    <= f_d;
            cnt_q  <= cnt_d;
        end
    end

    assign s_o   = s_q;
    assign f_o   = f_q;
    assign upd_o = upd;

endmodule : quad_input_filter

// File: rtl/quad_steer_decoder.sv
// -----------------------------------------------------------------------------
// quad_steer_decoder
//   Receive side of the steering quadrature path. Filters the A/B pair,
//   decodes Gray-code steps, keeps a wrapping position count, flags illegal
//   double-bit transitions and samples a saturated signed step count per
//   velocity window. Also serves as a loopback checker for the encoder.
//
// Parameters
//   FILTER_LEN  consecutive stable clocks to accept a new A/B value (>=1)
//   POS_W       position counter width (wraps modulo 2^POS_W)
//   VEL_W       signed velocity sample width
//   WINDOW      velocity window length in clocks (>=2)
//
// Ports
//   CLK          in   1      clock, rising edge
//   Reset_n      in   1      asynchronous active-low reset
//   clr_I        in   1      synchronous position clear (wins over a step)
//   A_I, B_I     in   1      quadrature phases, asynchronous
//   step_O       out  1      one-clock pulse per legal step
//   dir_O        out  1      direction of last legal step (1 = forward)
//   pos_O        out  POS_W  wrapping position count
//   vel_O        out  VEL_W  signed saturated steps in last completed window
//   vel_valid_O  out  1      one-clock pulse when vel_O updates
//   err_O        out  1      one-clock pulse on a double-bit transition
// -----------------------------------------------------------------------------
module quad_steer_decoder
    import quad_pkg::*;
#(
    parameter int FILTER_LEN = 4,
    parameter int POS_W      = 8,
    parameter int VEL_W      = 8,
    parameter int WINDOW     = 22500
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic             clr_I,
    input  logic             A_I,
    input  logic             B_I,
    output logic             step_O,
    output logic             dir_O,
    output logic [POS_W-1:0] pos_O,
    output logic [VEL_W-1:0] vel_O,
    output logic             vel_valid_O,
    output logic             err_O
);

    localparam int                      WIN_W    = $clog2(WINDOW);
    localparam logic [WIN_W-1:0]        WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic signed [VEL_W-1:0] VEL_MAX  = VEL_W'((2 ** (VEL_W - 1)) - 1);
    localparam logic signed [VEL_W-1:0] VEL_MIN  = -VEL_MAX;

    // ---------------------------------------------------------------------
    // Input synchronizer and joint stability filter
    // ---------------------------------------------------------------------
    logic [1:0] filt_s;
    logic [1:0] filt_f;
    logic       filt_upd;

    quad_input_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clk   (CLK),
        .rst_n (Reset_n),
        .a_i   (A_I),
        .b_i   (B_I),
        .s_o   (filt_s),
        .f_o   (filt_f),
        .upd_o (filt_upd)
    );

    // ---------------------------------------------------------------------
    // Decode, position and velocity state
    // ---------------------------------------------------------------------
    logic                    init_q, init_d;
    logic                    step_q, step_d;
    logic                    err_q, err_d;
    logic                    dir_q, dir_d;
    logic [POS_W-1:0]        pos_q, pos_d;
    logic signed [VEL_W-1:0] acc_q, acc_d;
    logic signed [VEL_W-1:0] acc_step;   // accumulator including this cycle's step
    logic [VEL_W-1:0]        vel_q, vel_d;
    logic                    vel_valid_q, vel_valid_d;
    logic [WIN_W-1:0]        win_q, win_d;
    quad_step_t              qs;

    always_comb begin
        qs     = quad_step(filt_f, filt_s);
        init_d = init_q;
        step_d = 1'b0;
        err_d  = 1'b0;
        dir_d  = dir_q;

        // The first filtered value after reset only establishes the starting
        // phase; treating it as a step would count a phantom move.
        if (filt_upd) begin
            if (init_q) begin
                init_d = 1'b0;
            end else if (!qs.legal) begin
                err_d = 1'b1;
            end else if (qs.move) begin
                step_d = 1'b1;
                dir_d  = qs.dir;
            end
        end

        // Position: clear overrides a coincident step; natural wrap in both directions.
        pos_d = pos_q;
        if (clr_I) begin
            pos_d = '0;
        end else if (step_d) begin
            pos_d = (qs.dir == DIR_FWD) ? pos_q + 1'b1 : pos_q - 1'b1;
        end

        // Velocity accumulator saturates symmetrically.
        acc_step = acc_q;
        if (step_d) begin
            if ((qs.dir == DIR_FWD) && (acc_q != VEL_MAX)) begin
                acc_step = acc_q + 1'b1;
            end else if ((qs.dir == DIR_REV) && (acc_q != VEL_MIN)) begin
                acc_step = acc_q - 1'b1;
            end
        end

        // The last cycle of the window publishes the sum including its own step.
        if (win_q == WIN_LAST) begin
            win_d       = '0;
            acc_d       = '0;
            vel_d       = acc_step;
            vel_valid_d = 1'b1;
        end else begin
            win_d       = win_q + 1'b1;
            acc_d       = acc_step;
            vel_d       = vel_q;
            vel_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            init_q      <= 1'b1;
            step_q      <= 1'b0;
            err_q       <= 1'b0;
            dir_q       <= DIR_REV;
            pos_q       <= '0;
            acc_q       <= '0;
            vel_q       <= '0;
            vel_valid_q <= 1'b0;
            win_q       <= '0;
        end else begin
            init_q      <= init_d;
            step_q      <= step_d;
            err_q       <= err_d;
            dir_q       <= dir_d;
            pos_q       <= pos_d;
            acc_q       <= acc_d;
            vel_q       <= vel_d;
            vel_valid_q <= vel_valid_d;
            win_q       <= win_d;
        end
    end

    assign step_O      = step_q;
    assign err_O       = err_q;
    assign dir_O       = dir_q;
    assign pos_O       = pos_q;
    assign vel_O       = vel_q;
    assign vel_valid_O = vel_valid_q;

endmodule : quad_steer_decoder

// File: tb/tb_quad_steer_decoder.sv
// -----------------------------------------------------------------------------
// tb_quad_steer_decoder
//   Main instance: FILTER_LEN=4, POS_W=8, VEL_W=8, WINDOW=100, checked every
//   clock against a reference model built from the input history.
//   Second instance: FILTER_LEN=1, WINDOW=256, used to reach velocity
//   saturation (more than 127 steps inside one window).
// -----------------------------------------------------------------------------
module tb_quad_steer_decoder;

    localparam int FL   = 4;
    localparam int WIN  = 100;
    localparam int PW   = 8;
    localparam int VW   = 8;
    localparam int VMAX = 127;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Main DUT
    logic          Reset_n, clr_I, A_I, B_I;
    logic          step_O, dir_O, vel_valid_O, err_O;
    logic [PW-1:0] pos_O;
    logic [VW-1:0] vel_O;

    quad_steer_decoder #(
        .FILTER_LEN (FL),
        .POS_W      (PW),
        .VEL_W      (VW),
        .WINDOW     (WIN)
    ) dut (
        .CLK         (CLK),
        .Reset_n     (Reset_n),
        .clr_I       (clr_I),
        .A_I         (A_I),
        .B_I         (B_I),
        .step_O      (step_O),
        .dir_O       (dir_O),
        .pos_O       (pos_O),
        .vel_O       (vel_O),
        .vel_valid_O (vel_valid_O),
        .err_O       (err_O)
    );

    // Saturation DUT
    logic          rst2_n, clr2, a2, b2;
    logic          step2, dir2, vel_valid2, err2;
    logic [PW-1:0] pos2;
    logic [VW-1:0] vel2;

    quad_steer_decoder #(
        .FILTER_LEN (1),
        .POS_W      (PW),
        .VEL_W      (VW),
        .WINDOW     (256)
    ) dut_fast (
        .CLK         (CLK),
        .Reset_n     (rst2_n),
        .clr_I       (clr2),
        .A_I         (a2),
        .B_I         (b2),
        .step_O      (step2),
        .dir_O       (dir2),
        .pos_O       (pos2),
        .vel_O       (vel2),
        .vel_valid_O (vel_valid2),
        .err_O       (err2)
    );

    int checks = 0;
    int errors = 0;
    logic [1:0] cur;

    // ------------------------------------------------------------------
    // Reference model
    //   hist[k] = {A,B} presented at the k-th most recent edge (k=0: this one).
    //   The filter sees the input of two edges ago; it adopts a value once
    //   the last FL seen samples all equal it and it differs from f.
    //   Steps are classified by distance around the Gray circle.
    // ------------------------------------------------------------------
    logic [1:0] hist [0:FL+1];
    logic [1:0] mf;
    logic       minit, mstep, merr, mdir, mvalid;
    int         mpos, macc, mvel, mwin;

    function automatic int gray_idx(input logic [1:0] v);
        case (v)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] gray_at(input int i);
        case (i & 3)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k <= FL + 1; k++) hist[k] = 2'b00;
        mf = 2'b00; minit = 1'b1; mstep = 1'b0; merr = 1'b0; mdir = 1'b0; mvalid = 1'b0;
        mpos = 0; macc = 0; mvel = 0; mwin = 0;
    endtask

    task automatic model_edge(input logic [1:0] ab, input logic clr);
        bit run_ok;
        int delta;
        for (int k = FL + 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = ab;
        run_ok = 1'b1;
        for (int k = 3; k <= FL + 1; k++) if (hist[k] != hist[2]) run_ok = 1'b0;
        delta = 0; mstep = 1'b0; merr = 1'b0;
        if (run_ok && hist[2] != mf) begin
            if (minit) begin
                minit = 1'b0;
            end else begin
                case ((gray_idx(hist[2]) - gray_idx(mf)) & 3)
                    1:       begin mstep = 1'b1; mdir = 1'b1; delta = 1;  end
                    3:       begin mstep = 1'b1; mdir = 1'b0; delta = -1; end
                    default: merr = 1'b1;
                endcase
            end
            mf = hist[2];
        end
        mpos = clr ? 0 : (((mpos + delta) % 256) + 256) % 256;
        macc = macc + delta;
        if (macc > VMAX) macc = VMAX;
        if (macc < -VMAX) macc = -VMAX;
        if (mwin == WIN - 1) begin
            mvel = macc; mvalid = 1'b1; macc = 0; mwin = 0;
        end else begin
            mvalid = 1'b0; mwin++;
        end
    endtask

    function automatic logic [19:0] dut_vec();
        return {step_O, err_O, dir_O, pos_O, vel_O, vel_valid_O};
    endfunction

    function automatic logic [19:0] exp_vec();
        return {mstep, merr, mdir, 8'(mpos), 8'(mvel), mvalid};
    endfunction

    // Drive one clock of stimulus (we sit on a falling edge), advance the model
    // on the rising edge, and return at the next falling edge for sampling.
    task automatic tick(input logic [1:0] ab, input logic clr);
        {A_I, B_I} = ab;
        clr_I      = clr;
        cur        = ab;
        @(posedge CLK);
        if (Reset_n) model_edge(ab, clr);
        @(negedge CLK);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        Reset_n = 1'b0; clr_I = 1'b0; {A_I, B_I} = 2'b11; cur = 2'b11;
        model_reset();
        repeat (3) @(negedge CLK);
        checks++;
        if (dut_vec() !== 20'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 00000", dut_vec());
        end
        Reset_n = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick(2'b11, 1'b0);
            checks++;
            if ({step_O, err_O, pos_O} !== 10'd0) begin
                errors++;
                $display("FAIL init_silent cycle %0d: got step=%b err=%b pos=%0d expected 0/0/0",
                         i, step_O, err_O, pos_O);
            end
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL init_model cycle %0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_forward();
        logic [1:0] seq [3];
        logic       exp_s;
        seq = '{2'b10, 2'b00, 2'b01};
        for (int s = 0; s < 3; s++) begin
            for (int i = 1; i <= 10; i++) begin
                tick(seq[s], 1'b0);
                exp_s = (i == 6);
                checks++;
                if (step_O !== exp_s) begin
                    errors++;
                    $display("FAIL fwd_latency step %0d clk %0d: got %b expected %b", s, i, step_O, exp_s);
                end
                checks++;
                if (dut_vec() !== exp_vec()) begin
                    errors++;
                    $display("FAIL fwd_model clk %0d: got %h expected %h", i, dut_vec(), exp_vec());
                end
            end
        end
        checks++;
        if (dir_O !== 1'b1 || pos_O !== 8'd3) begin
            errors++;
            $display("FAIL fwd_final: got dir=%b pos=%0d expected dir=1 pos=3", dir_O, pos_O);
        end
    endtask

    task automatic test_reverse_wrap();
        for (int i = 1; i <= 6; i++) begin
            tick(2'b01, i == 1);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL clr_model clk %0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (pos_O !== 8'd0) begin
            errors++;
            $display("FAIL clear_to_zero: got pos=%0d expected 0", pos_O);
        end
        for (int i = 1; i <= 10; i++) tick(2'b00, 1'b0);
        checks++;
        if (pos_O !== 8'd255 || dir_O !== 1'b0) begin
            errors++;
            $display("FAIL rev_wrap: got pos=%0d dir=%b expected pos=255 dir=0", pos_O, dir_O);
        end
        for (int i = 1; i <= 10; i++) tick(2'b01, 1'b0);
        checks++;
        if (pos_O !== 8'd0 || dir_O !== 1'b1) begin
            errors++;
            $display("FAIL fwd_wrap: got pos=%0d dir=%b expected pos=0 dir=1", pos_O, dir_O);
        end
    endtask

    task automatic test_glitch();
        int steps;
        steps = 0;
        for (int r = 0; r < 2; r++) begin
            for (int i = 1; i <= 10; i++) begin
                tick((i <= 3) ? 2'b11 : 2'b01, 1'b0);
                steps += int'(step_O);
                checks++;
                if (dut_vec() !== exp_vec()) begin
                    errors++;
                    $display("FAIL glitch_model clk %0d: got %h expected %h", i, dut_vec(), exp_vec());
                end
            end
        end
        checks++;
        if (steps != 0 || pos_O !== 8'd0) begin
            errors++;
            $display("FAIL glitch_rejected: got steps=%0d pos=%0d expected 0/0", steps, pos_O);
        end
        steps = 0;
        for (int i = 1; i <= 10; i++) begin
            tick(2'b11, 1'b0);
            steps += int'(step_O);
        end
        checks++;
        if (steps != 1 || pos_O !== 8'd1) begin
            errors++;
            $display("FAIL stable_accepted: got steps=%0d pos=%0d expected 1/1", steps, pos_O);
        end
    endtask

    task automatic test_illegal();
        int steps, errs;
        for (int i = 1; i <= 10; i++) tick(2'b10, 1'b0);
        for (int i = 1; i <= 10; i++) tick(2'b00, 1'b0);
        steps = 0; errs = 0;
        for (int i = 1; i <= 10; i++) begin
            tick(2'b11, 1'b0);
            steps += int'(step_O);
            errs  += int'(err_O);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL illegal_model clk %0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (errs != 1 || steps != 0 || pos_O !== 8'd3 || dir_O !== 1'b1) begin
            errors++;
            $display("FAIL illegal_jump: got err=%0d step=%0d pos=%0d dir=%b expected 1/0/3/1",
                     errs, steps, pos_O, dir_O);
        end
        for (int i = 1; i <= 10; i++) tick(2'b10, 1'b0);
        checks++;
        if (pos_O !== 8'd4 || dir_O !== 1'b1) begin
            errors++;
            $display("FAIL after_illegal: got pos=%0d dir=%b expected 4/1", pos_O, dir_O);
        end
    endtask

    task automatic test_velocity();
        logic [1:0] v;
        logic       exp_valid;
        Reset_n = 1'b0;
        model_reset();
        @(negedge CLK);
        Reset_n = 1'b1;
        for (int t = 1; t <= 200; t++) begin
            if (t <= 6)        v = 2'b01;
            else if (t <= 66)  v = gray_at(2 + (t - 7) / 6);
            else if (t <= 194) v = 2'b10;
            else               v = 2'b00;
            tick(v, 1'b0);
            exp_valid = (t == 100) || (t == 200);
            checks++;
            if (vel_valid_O !== exp_valid) begin
                errors++;
                $display("FAIL vel_valid_timing clk %0d: got %b expected %b", t, vel_valid_O, exp_valid);
            end
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL vel_model clk %0d: got %h expected %h", t, dut_vec(), exp_vec());
            end
            if (t == 100) begin
                checks++;
                if (vel_O !== 8'd10) begin
                    errors++;
                    $display("FAIL vel_10_steps: got %0d expected 10", vel_O);
                end
            end
            if (t == 200) begin
                checks++;
                if (vel_O !== 8'd1 || step_O !== 1'b1) begin
                    errors++;
                    $display("FAIL vel_last_clock_step: got vel=%0d step=%b expected 1/1", vel_O, step_O);
                end
            end
        end
    endtask

    task automatic test_clear();
        for (int i = 1; i <= 8; i++) begin
            tick(2'b01, i == 6);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL clear_model clk %0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
            if (i == 6) begin
                checks++;
                if (step_O !== 1'b1 || pos_O !== 8'd0 || dir_O !== 1'b1) begin
                    errors++;
                    $display("FAIL clear_vs_step: got step=%b pos=%0d dir=%b expected 1/0/1",
                             step_O, pos_O, dir_O);
                end
            end
        end
    endtask

    task automatic test_random();
        int         n, hold, kind;
        logic [1:0] nxt;
        logic       clr;
        n = 0;
        while (n < 1500) begin
            kind = $urandom_range(0, 99);
            if (kind < 15)      nxt = cur ^ 2'b11;
            else if (kind < 60) nxt = gray_at(gray_idx(cur) + 1);
            else                nxt = gray_at(gray_idx(cur) + 3);
            hold = $urandom_range(1, 7);
            for (int j = 0; j < hold; j++) begin
                clr = ($urandom_range(0, 99) < 3);
                tick(nxt, clr);
                checks++;
                if (dut_vec() !== exp_vec()) begin
                    errors++;
                    $display("FAIL random_model cycle %0d: got %h expected %h", n + j, dut_vec(), exp_vec());
                end
            end
            n += hold;
        end
    endtask

    task automatic test_async_reset();
        int steps;
        for (int i = 1; i <= 10; i++) tick(gray_at(gray_idx(cur) + 1), 1'b0);
        #2;
        Reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_vec() !== 20'd0) begin
            errors++;
            $display("FAIL async_reset: got %h expected 00000", dut_vec());
        end
        @(negedge CLK);
        Reset_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick(2'b11, 1'b0);
            checks++;
            if (step_O !== 1'b0 || err_O !== 1'b0 || dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reinit_silent clk %0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
        steps = 0;
        for (int i = 1; i <= 10; i++) begin
            tick(2'b10, 1'b0);
            steps += int'(step_O);
        end
        checks++;
        if (steps != 1 || pos_O !== 8'd1 || dir_O !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_step: got steps=%0d pos=%0d dir=%b expected 1/1/1", steps, pos_O, dir_O);
        end
    endtask

    task automatic test_saturation();
        int steps, errs;
        steps = 0; errs = 0;
        @(negedge CLK);
        rst2_n = 1'b1;
        for (int t = 1; t <= 512; t++) begin
            {a2, b2} = (t <= 201) ? gray_at(t) : gray_at(201);
            @(posedge CLK);
            @(negedge CLK);
            steps += int'(step2);
            errs  += int'(err2);
            if (t == 256) begin
                checks++;
                if (vel_valid2 !== 1'b1 || vel2 !== 8'(VMAX)) begin
                    errors++;
                    $display("FAIL vel_saturate: got valid=%b vel=%0d expected 1/127", vel_valid2, vel2);
                end
            end
            if (t == 512) begin
                checks++;
                if (vel_valid2 !== 1'b1 || vel2 !== 8'd0) begin
                    errors++;
                    $display("FAIL vel_idle_window: got valid=%b vel=%0d expected 1/0", vel_valid2, vel2);
                end
            end
        end
        checks++;
        if (steps != 200 || errs != 0 || pos2 !== 8'd200 || dir2 !== 1'b1) begin
            errors++;
            $display("FAIL fast_steps: got steps=%0d err=%0d pos=%0d dir=%b expected 200/0/200/1",
                     steps, errs, pos2, dir2);
        end
    endtask

    initial begin
        rst2_n = 1'b0; clr2 = 1'b0; a2 = 1'b0; b2 = 1'b0;
        test_reset();
        test_forward();
        test_reverse_wrap();
        test_glitch();
        test_illegal();
        test_velocity();
        test_clear();
        test_random();
        test_async_reset();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_quad_steer_decoder
